// File: rtl/key_hc165_scan_if.sv
// Pin and PIO-side signal bundle for the 74HC165 key scanner.
// master = scanner side, slave = chip chain / system side.
interface key_hc165_scan_if #(
   parameter int unsigned NBITS = 8
);
   logic             sr_clk;
   logic             sr_ld_n;
   logic             sr_dat;
   logic [NBITS-1:0] raw;
   logic             scan_done;
   logic [NBITS-1:0] keys;
   logic [NBITS-1:0] key_press;

   modport master (
      output sr_clk, sr_ld_n, raw, scan_done, keys, key_press,
      input  sr_dat
   );

   modport slave (
      input  sr_clk, sr_ld_n, raw, scan_done, keys, key_press,
      output sr_dat
   );
endinterface

// File: rtl/key_hc165_scan.sv
// Periodic 74HC165 chain reader: load, shift NBITS in MSB-first,
// then debounce each bit and report a stable key vector plus press pulses.
module key_hc165_scan #(
   parameter int unsigned NBITS       = 8,
   parameter int unsigned CLK_DIV     = 25,
   parameter int unsigned SCAN_PERIOD = 50000,
   parameter int unsigned DEB_CNT     = 4,
   parameter int unsigned INVERT      = 1
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   key_hc165_scan_if.master    bus
);

   localparam int unsigned TMR_MAX = (CLK_DIV > SCAN_PERIOD) ? CLK_DIV : SCAN_PERIOD;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam int unsigned IDX_W   = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam int unsigned CNT_W   = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      SHIFT_LO,
      SHIFT_HI,
      DONE
   } state_t;

   state_t                       state_q, state_d;
   logic [TMR_W-1:0]             tmr_q, tmr_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [NBITS-1:0]             shreg_q, shreg_d;
   logic                         dat_s1_q, dat_s2_q;
   logic [NBITS-1:0]             raw_q, raw_d;
   logic [NBITS-1:0]             keys_q, keys_d;
   logic [NBITS-1:0]             press_q, press_d;
   logic                         done_q, done_d;
   logic                         sr_clk_q, sr_clk_d;
   logic                         sr_ld_n_q, sr_ld_n_d;
   logic [NBITS-1:0][CNT_W-1:0]  cnt_q, cnt_d;

   logic                         div_end;
   logic                         per_end;
   logic [NBITS-1:0]             scan_val;

   assign div_end  = (tmr_q == TMR_W'(CLK_DIV - 1));
   assign per_end  = (tmr_q == TMR_W'(SCAN_PERIOD - 1));
   assign scan_val = (INVERT != 0) ? ~shreg_q : shreg_q;

   // State and datapath registers; sr_dat crosses in through two flops.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         tmr_q     <= '0;
         idx_q     <= '0;
         shreg_q   <= '0;
         dat_s1_q  <= 1'b0;
         dat_s2_q  <= 1'b0;
         raw_q     <= '0;
         keys_q    <= '0;
         press_q   <= '0;
         done_q    <= 1'b0;
         sr_clk_q  <= 1'b0;
         sr_ld_n_q <= 1'b1;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         dat_s1_q  <= bus.sr_dat;
         dat_s2_q  <= dat_s1_q;
         raw_q     <= raw_d;
         keys_q    <= keys_d;
         press_q   <= press_d;
         done_q    <= done_d;
         sr_clk_q  <= sr_clk_d;
         sr_ld_n_q <= sr_ld_n_d;
         cnt_q     <= cnt_d;
      end
   end

   // Next-state, datapath and pin decode.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q + TMR_W'(1);
      idx_d   = idx_q;
      shreg_d = shreg_q;
      raw_d   = raw_q;
      keys_d  = keys_q;
      press_d = '0;
      done_d  = 1'b0;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (per_end) begin
               state_d = LOAD;
               tmr_d   = '0;
            end
         end
         LOAD: begin
            if (div_end) begin
               state_d = SETTLE;
               tmr_d   = '0;
            end
         end
         SETTLE: begin
            if (div_end) begin
               state_d = SHIFT_LO;
               tmr_d   = '0;
               idx_d   = '0;
            end
         end
         SHIFT_LO: begin
            // Sample just before the rising sr_clk edge that advances the chain.
            if (div_end) begin
               shreg_d = NBITS'({shreg_q, dat_s2_q});
               state_d = SHIFT_HI;
               tmr_d   = '0;
            end
         end
         SHIFT_HI: begin
            if (div_end) begin
               tmr_d = '0;
               if (idx_q == IDX_W'(NBITS - 1)) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = SHIFT_LO;
               end
            end
         end
         DONE: begin
            raw_d   = scan_val;
            done_d  = 1'b1;
            state_d = IDLE;
            tmr_d   = '0;
            // A bit flips only after DEB_CNT consecutive disagreeing scans.
            for (int i = 0; i < int'(NBITS); i++) begin
               if (scan_val[i] == keys_q[i]) begin
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == CNT_W'(DEB_CNT - 1)) begin
                  keys_d[i]  = scan_val[i];
                  press_d[i] = scan_val[i];
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            tmr_d   = '0;
         end
      endcase

      sr_clk_d  = (state_d == SHIFT_HI);
      sr_ld_n_d = (state_d != LOAD);
   end

   assign bus.sr_clk    = sr_clk_q;
   assign bus.sr_ld_n   = sr_ld_n_q;
   assign bus.raw       = raw_q;
   assign bus.scan_done = done_q;
   assign bus.keys      = keys_q;
   assign bus.key_press = press_q;

endmodule

// File: tb/tb_key_hc165_scan.sv
// Bench for key_hc165_scan: behavioural 74HC165 models, a per-scan scoreboard
// fed from a vector table, and hand sequences for timing and mid-scan reset.
module tb_key_hc165_scan;

   typedef struct {
      logic [7:0] pins;
      logic [7:0] raw;
      logic [7:0] keys;
      logic [7:0] press;
   } vec_t;

   logic sys_clk;
   logic rst_n;
   logic [7:0] pins8;
   logic [7:0] near_pins, far_pins;
   logic [7:0] m8;
   logic [7:0] near_q, far_q;

   int n_cmp = 0;
   int n_err = 0;

   vec_t sb[$];
   vec_t tbl[$];

   key_hc165_scan_if #(.NBITS(8))  bus8 ();
   key_hc165_scan_if #(.NBITS(16)) bus16 ();

   key_hc165_scan #(
      .NBITS(8), .CLK_DIV(2), .SCAN_PERIOD(10), .DEB_CNT(3), .INVERT(1)
   ) u_dut8 (
      .sys_clk  (sys_clk),
      .sys_rst_n(rst_n),
      .bus      (bus8)
   );

   key_hc165_scan #(
      .NBITS(16), .CLK_DIV(2), .SCAN_PERIOD(10), .DEB_CNT(3), .INVERT(1)
   ) u_dut16 (
      .sys_clk  (sys_clk),
      .sys_rst_n(rst_n),
      .bus      (bus16)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Single 165: async parallel load while SH/LD low, shift on CLK rise, SER tied high.
   always @(posedge bus8.sr_clk or negedge bus8.sr_ld_n) begin
      if (!bus8.sr_ld_n) m8 <= pins8;
      else               m8 <= {m8[6:0], 1'b1};
   end
   assign bus8.sr_dat = m8[7];

   // Two cascaded 165s: far chip QH feeds near chip SER, near chip QH feeds the scanner.
   always @(posedge bus16.sr_clk or negedge bus16.sr_ld_n) begin
      if (!bus16.sr_ld_n) begin
         near_q <= near_pins;
         far_q  <= far_pins;
      end else begin
         near_q <= {near_q[6:0], far_q[7]};
         far_q  <= {far_q[6:0], 1'b1};
      end
   end
   assign bus16.sr_dat = near_q[7];

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Scoreboard: every scan_done pops one expected record; pulses outside scan_done are errors.
   always @(negedge sys_clk) begin
      if (rst_n) begin
         if (bus8.scan_done) begin
            if (sb.size() == 0) begin
               check("unexpected_scan_done", 32'd1, 32'd0);
            end else begin
               vec_t e;
               e = sb.pop_front();
               check("raw", 32'(bus8.raw), 32'(e.raw));
               check("keys", 32'(bus8.keys), 32'(e.keys));
               check("key_press", 32'(bus8.key_press), 32'(e.press));
            end
         end else if (bus8.key_press != 8'h00) begin
            check("stray_key_press", 32'(bus8.key_press), 32'd0);
         end
      end
   end

   task automatic wait_done8(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!bus8.scan_done && n < budget);
      if (!bus8.scan_done) check("scan_done_timeout", 32'd0, 32'd1);
   endtask

   task automatic count_to_load(input string name);
      int c;
      c = 0;
      do begin
         @(negedge sys_clk);
         c++;
      end while (bus8.sr_ld_n && c < 100);
      check(name, 32'(c), 32'd10);
   endtask

   task automatic add(input logic [7:0] p, input logic [7:0] r, input logic [7:0] k,
                      input logic [7:0] kp);
      vec_t v;
      v.pins = p; v.raw = r; v.keys = k; v.press = kp;
      tbl.push_back(v);
   endtask

   initial begin
      int low, d, rises, n;
      logic prev_clk;
      vec_t v;

      // Press, hold, release, bounce, bit order, two-key press.
      add(8'hFE, 8'h01, 8'h00, 8'h00);
      add(8'hFE, 8'h01, 8'h00, 8'h00);
      add(8'hFE, 8'h01, 8'h01, 8'h01);
      add(8'hFE, 8'h01, 8'h01, 8'h00);
      add(8'hFF, 8'h00, 8'h01, 8'h00);
      add(8'hFF, 8'h00, 8'h01, 8'h00);
      add(8'hFF, 8'h00, 8'h00, 8'h00);
      for (int k = 0; k < 10; k++) begin
         if (k % 2 == 0) add(8'hFE, 8'h01, 8'h00, 8'h00);
         else            add(8'hFF, 8'h00, 8'h00, 8'h00);
      end
      add(8'h7F, 8'h80, 8'h00, 8'h00);
      add(8'hFC, 8'h03, 8'h00, 8'h00);
      add(8'hFC, 8'h03, 8'h00, 8'h00);
      add(8'hFC, 8'h03, 8'h03, 8'h03);
      add(8'hFC, 8'h03, 8'h03, 8'h00);

      rst_n     = 1'b0;
      pins8     = 8'hFF;
      near_pins = 8'hFF;
      far_pins  = 8'hFE;
      repeat (3) @(negedge sys_clk);
      check("rst_sr_ld_n", 32'(bus8.sr_ld_n), 32'd1);
      check("rst_sr_clk", 32'(bus8.sr_clk), 32'd0);
      check("rst_keys", 32'(bus8.keys), 32'd0);
      check("rst_raw", 32'(bus8.raw), 32'd0);

      // First scan: load timing, load width, edge count, scan length.
      v.pins = 8'hFF; v.raw = 8'h00; v.keys = 8'h00; v.press = 8'h00;
      sb.push_back(v);
      rst_n = 1'b1;
      count_to_load("first_load_delay");
      low = 0;
      while (!bus8.sr_ld_n && low < 100) begin
         @(negedge sys_clk);
         low++;
      end
      check("ld_low_cycles", 32'(low), 32'd2);
      d        = low;
      rises    = 0;
      prev_clk = bus8.sr_clk;
      while (!bus8.scan_done && d < 200) begin
         @(negedge sys_clk);
         d++;
         if (bus8.sr_clk && !prev_clk) rises++;
         prev_clk = bus8.sr_clk;
      end
      check("load_to_scan_done", 32'(d), 32'd37);
      check("sr_clk_rises", 32'(rises), 32'd8);

      foreach (tbl[i]) begin
         pins8 = tbl[i].pins;
         sb.push_back(tbl[i]);
         wait_done8(100);
      end

      // Reset in the middle of SHIFT_HI with keys held.
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!bus8.sr_clk && n < 100);
      check("reach_shift_hi", 32'(bus8.sr_clk), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_sr_clk", 32'(bus8.sr_clk), 32'd0);
      check("midrst_sr_ld_n", 32'(bus8.sr_ld_n), 32'd1);
      check("midrst_keys", 32'(bus8.keys), 32'd0);
      check("midrst_raw", 32'(bus8.raw), 32'd0);
      check("midrst_sb_drained", 32'(sb.size()), 32'd0);
      pins8 = 8'h5A;
      @(negedge sys_clk);
      @(negedge sys_clk);
      v.pins = 8'h5A; v.raw = 8'hA5; v.keys = 8'h00; v.press = 8'h00;
      sb.push_back(v);
      rst_n = 1'b1;
      count_to_load("post_rst_load_delay");
      wait_done8(100);

      // Cascaded pair: far chip pressed on D0, near chip idle.
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!bus16.scan_done && n < 300);
      check("cascade_scan_done", 32'(bus16.scan_done), 32'd1);
      check("cascade_raw", 32'(bus16.raw), 32'h0001);

      check("sb_leftover", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/key_hc165_scan.md
Name: key_hc165_scan

Overview:
Serial-in reader for a 74HC165 parallel-in/serial-out shift-register chain. It is the input-side counterpart of the 74HC595 segment-LED driver. The block periodically loads the chip, shifts NBITS key or switch states in MSB-first, and debounces each bit. It presents a stable key vector and press pulses to the system as PIO input bits.

Parameters:
NBITS, 8, number of serial bits per scan (8 per cascaded 165).
CLK_DIV, 25, sys_clk cycles per half-period of sr_clk and per load/settle phase; must be >= 1.
SCAN_PERIOD, 50000, sys_clk cycles idle between scans (1 ms at 50 MHz); must be >= 1.
DEB_CNT, 4, consecutive disagreeing scans required to flip a debounced bit; must be >= 1.
INVERT, 1, 1 = inputs are pulled up (pressed reads 0), so raw data is inverted before use.

Ports:
sys_clk  in  1  system clock, 50 MHz.
sys_rst_n  in  1  asynchronous active-low reset.
sr_clk  out  1  165 CLK pin; shift on rising edge.
sr_ld_n  out  1  165 SH/LD pin; low = parallel load.
sr_dat  in  1  165 QH serial data.
raw  out  NBITS  last scan result after optional inversion, undebounced.
scan_done  out  1  one-cycle pulse when raw updates.
keys  out  NBITS  debounced key state, 1 = pressed.
key_press  out  NBITS  one-cycle per-bit pulse on a keys 0->1 transition.

Behaviour:
- Reset (asynchronous, immediate, also mid-scan):
  - State goes to IDLE.
  - sr_clk=0, sr_ld_n=1.
  - raw=0, keys=0, key_press=0, scan_done=0.
  - All counters, the shift register and the debounce counters are cleared.
- sr_dat is passed through a 2-flop synchronizer before use. Sampling points below refer to the synchronized value. CLK_DIV >= 2 guarantees that settle time covers the synchronizer.
- FSM states: IDLE, LOAD, SETTLE, SHIFT_LO, SHIFT_HI, DONE.
- IDLE:
  - sr_clk=0, sr_ld_n=1.
  - The period counter counts SCAN_PERIOD cycles, then the FSM goes to LOAD.
  - The first sr_ld_n fall therefore occurs SCAN_PERIOD cycles after reset release.
- LOAD: sr_ld_n=0 for exactly CLK_DIV cycles, then go to SETTLE.
- SETTLE: sr_ld_n=1, sr_clk=0 for CLK_DIV cycles, then go to SHIFT_LO with bit index 0.
- SHIFT_LO:
  - sr_clk=0 for CLK_DIV cycles.
  - On the last cycle, shift the synchronized sr_dat into the shift register LSB (shift left).
  - Then go to SHIFT_HI.
- SHIFT_HI:
  - sr_clk=1 for CLK_DIV cycles.
  - At the end, if bit index == NBITS-1 go to DONE; otherwise increment the index and go to SHIFT_LO.
  - Exactly NBITS rising edges occur per scan; the last edge is harmless.
- Bit order: the first sampled bit is 165 input D7 (H) and ends in raw[NBITS-1]; the last sampled bit ends in raw[0].
- DONE (one cycle):
  - raw <= INVERT ? ~shreg : shreg.
  - scan_done=1 in the following cycle, aligned with the raw update.
  - Debounce update runs (see below), then the FSM returns to IDLE with the period counter cleared.
- Scan length: 2*CLK_DIV + 2*CLK_DIV*NBITS + 1 cycles (451 at defaults). The scan-to-scan interval is that length plus SCAN_PERIOD.
- Debounce, per bit i, evaluated in DONE on the new raw value r:
  - If r[i]==keys[i], then cnt[i]=0.
  - Else if cnt[i]==DEB_CNT-1, then keys[i]=r[i] and cnt[i]=0.
  - Else cnt[i] increments.
  - With DEB_CNT=1, keys follows raw every scan.
  - cnt width is clog2(DEB_CNT) with a minimum of 1.
- key_press[i] is 1 for exactly one cycle, in the cycle keys[i] rises. Releases produce no pulse.
- keys, raw and scan_done update in the same cycle.
- Multiple bits may change in one scan; their pulses are simultaneous.
- Outputs are registered; there are no combinational paths from sr_dat to any output.

Test Plan:
Common bench settings: CLK_DIV=2, SCAN_PERIOD=10, DEB_CNT=3, INVERT=1, NBITS=8, behavioral 165 model, parallel inputs idle at 8'hFF.
1. Reset release -> sr_ld_n=1, sr_clk=0, keys=0. First sr_ld_n fall exactly 10 cycles later. sr_ld_n low 2 cycles. 8 sr_clk rising edges. scan_done at 2+2+32+1 cycles after load start. raw=8'h00.
2. Inputs 8'hFE held -> raw=8'h01 after scan 1. keys=8'h01 at the scan_done of scan 3, with key_press=8'h01 for one cycle. keys unchanged at scan 4 with no pulse.
3. Bit order: inputs 8'h7F -> raw=8'h80. Inputs 8'hFE with NBITS=16 on two cascaded models (second chip 8'hFF) -> raw=16'h0001.
4. Bounce: inputs alternate 8'hFE/8'hFF on successive scans for 10 scans -> raw toggles 8'h01/8'h00, keys stays 8'h00, key_press never asserted.
5. Release after test 2: inputs 8'hFF -> keys=8'h00 at the 3rd scan. key_press stays 0. Two keys pressed together (8'hFC) -> key_press=8'h03 in a single cycle.
6. Assert sys_rst_n low during SHIFT_HI -> same cycle sr_clk=0, sr_ld_n=1, keys=0, raw=0. After release, the next load occurs 10 cycles later and a full 8-bit scan completes correctly.
